// File: rtl/funcao_tt_checker_if.sv
// rtl/funcao_tt_checker_if.sv - stimulus/response bundle between truth-table checker and its controller
interface funcao_tt_checker_if;
  logic       start;
  logic       abort;
  logic       a_o;
  logic       b_o;
  logic       c_o;
  logic       f_i;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] tt_captured;
  logic [7:0] err_mask;
  logic [3:0] err_count;

  modport master (
    output start, abort, f_i,
    input  a_o, b_o, c_o, busy, done, pass, tt_captured, err_mask, err_count
  );

  modport slave (
    input  start, abort, f_i,
    output a_o, b_o, c_o, busy, done, pass, tt_captured, err_mask, err_count
  );
endinterface

// File: rtl/funcao_tt_checker.sv
// rtl/funcao_tt_checker.sv - exhaustive 3-input truth-table sweep and compare
// Optional macro FUNCAO_TT_SYNC_EN: double-flop synchronizer on f_i, HOLD lengthened by 2 cycles.
module funcao_tt_checker #(
  parameter logic [7:0]  EXPECTED      = 8'hE8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  funcao_tt_checker_if.slave bus
);

`ifdef FUNCAO_TT_SYNC_EN
  localparam int unsigned HOLD_LEN = SETTLE_CYCLES + 2;
`else
  localparam int unsigned HOLD_LEN = SETTLE_CYCLES;
`endif
  localparam logic [4:0] HOLD_LAST = 5'(HOLD_LEN - 1);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FINISH} state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] tt_q, tt_d;
  logic [7:0] mask_q, mask_d;
  logic [3:0] errc_q, errc_d;
  logic       f_cap;
  logic [7:0] mask_calc;
  logic [3:0] ones;

`ifdef FUNCAO_TT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.f_i};
    end
  end

  assign f_cap = sync_q[1];
`else
  assign f_cap = bus.f_i;
`endif

  always_comb begin
    mask_calc = tt_q ^ EXPECTED;
    ones      = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'b000, mask_calc[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abc_d   = abc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    tt_d    = tt_q;
    mask_d  = mask_q;
    errc_d  = errc_q;

    case (state_q)
      IDLE: begin
        // abort dominates a coincident start
        if (!bus.abort && bus.start) begin
          tt_d    = 8'h00;
          mask_d  = 8'h00;
          errc_d  = 4'd0;
          pass_d  = 1'b0;
          idx_d   = 3'd0;
          cnt_d   = 5'd0;
          abc_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == HOLD_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        tt_d[idx_q] = f_cap;
        if (idx_q == 3'd7) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + 3'd1;
          abc_d   = idx_q + 3'd1;
          cnt_d   = 5'd0;
          state_d = HOLD;
        end
      end
      FINISH: begin
        mask_d  = mask_calc;
        errc_d  = ones;
        pass_d  = (tt_q == EXPECTED);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        abc_d   = 3'd0;
        idx_d   = 3'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // an aborted sample edge does not capture; bits taken earlier are kept
    if (bus.abort && (state_q == HOLD || state_q == SAMPLE)) begin
      tt_d    = tt_q;
      state_d = IDLE;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
      abc_d   = 3'd0;
      idx_d   = 3'd0;
      cnt_d   = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 5'd0;
      abc_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tt_q    <= 8'h00;
      mask_q  <= 8'h00;
      errc_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tt_q    <= tt_d;
      mask_q  <= mask_d;
      errc_q  <= errc_d;
    end
  end

  assign bus.a_o         = abc_q[2];
  assign bus.b_o         = abc_q[1];
  assign bus.c_o         = abc_q[0];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.tt_captured = tt_q;
  assign bus.err_mask    = mask_q;
  assign bus.err_count   = errc_q;

endmodule

// File: doc/funcao_tt_checker.md
Name: funcao_tt_checker

Overview:
- Hardware response checker for 3-input combinational functions of the funcao_N family.
- Sweeps the 8 input vectors onto the DUT's A, B and C inputs and samples the DUT output F once per vector.
- Assembles the captured truth table and compares it with an expected constant, reporting pass/fail, the failing minterms and an error count.
- Sits beside the function under test in self-checking builds; it is the sampling/checking end of the exhaustive-stimulus flow.

Parameters:
- EXPECTED, 8'hE8, expected truth table; bit k is the F value for vector k, where k = {A,B,C} and A is the MSB.
- SETTLE_CYCLES, 2, number of cycles each vector is held before its sampling edge; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE without asserting done.
- a_o  output  1  drives DUT input A (vector index bit 2).
- b_o  output  1  drives DUT input B (vector index bit 1).
- c_o  output  1  drives DUT input C (vector index bit 0).
- f_i  input  1  DUT output F.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when tt_captured equals EXPECTED; valid from done until the next start.
- tt_captured  output  8  captured truth table.
- err_mask  output  8  tt_captured XOR EXPECTED.
- err_count  output  4  population count of err_mask (0..8).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE, idx=0.
  - a_o, b_o, c_o = 0; busy, done, pass = 0.
  - tt_captured, err_mask, err_count = 0.
  - Settle counter = 0.
- FSM states: IDLE, HOLD, SAMPLE, FINISH.
- IDLE:
  - If start=1 at edge E0: clear tt_captured, err_mask, err_count and pass; set idx=0 and busy=1; go to HOLD.
- HOLD:
  - {a_o,b_o,c_o} = idx, registered outputs.
  - Settle counter increments each cycle; after SETTLE_CYCLES cycles in HOLD, go to SAMPLE.
- SAMPLE (one cycle):
  - At this edge, tt_captured[idx] <= f_i.
  - If idx=7, go to FINISH; otherwise idx <= idx+1, counter <= 0, go to HOLD.
- Timing consequences:
  - Each vector is applied for SETTLE_CYCLES+1 cycles.
  - Vector k is sampled at edge E0 + (SETTLE_CYCLES+1)*(k+1).
  - The last sample is at E0 + 8*(SETTLE_CYCLES+1); this is E0+24 with the default.
- FINISH (one cycle):
  - err_mask, err_count and pass are computed combinationally from tt_captured and registered at this edge.
  - done=1 and busy=0 for exactly that one cycle; return to IDLE.
  - pass, tt_captured, err_mask and err_count hold until the next start or reset.
- Outputs during a sweep:
  - a_o, b_o, c_o return to 000 in IDLE.
  - tt_captured bits not yet sampled read 0.
- start while busy is ignored; no restart and no queuing.
- abort=1 in HOLD or SAMPLE:
  - Next state IDLE; busy=0; done stays 0; pass=0.
  - tt_captured retains the bits sampled so far; err_mask and err_count stay 0.
- abort in FINISH is ignored; the sweep completes normally.
- abort and start both high in IDLE: abort wins and the FSM stays in IDLE.
- Reset mid-sweep has the full reset effect immediately; no done pulse is produced.
- Width rules: idx is 3 bits and never wraps within a sweep; err_count is a 4-bit sum of 8 single bits.

Optional Feature:
- Macro FUNCAO_TT_SYNC_EN.
- Defined:
  - f_i passes through a 2-flop synchronizer before capture.
  - Each vector's HOLD phase lengthens by 2 cycles, so vector k is sampled at E0 + (SETTLE_CYCLES+3)*(k+1).
  - done occurs 16 cycles later than without the macro.
- Undefined: f_i is sampled directly, with the timing given above.

Test Plan:
- Test 1:
  - Stimulus: default parameters; f_i driven by a majority(A,B,C) model; pulse start.
  - Response: busy for 25 cycles; done at E0+25; tt_captured=8'hE8; err_mask=0; err_count=0; pass=1.
- Test 2:
  - Stimulus: f_i stuck at 0.
  - Response: tt_captured=8'h00; err_mask=8'hE8; err_count=4; pass=0.
- Test 3:
  - Stimulus: f_i = NOT majority.
  - Response: tt_captured=8'h17; err_mask=8'hFF; err_count=8; pass=0.
- Test 4:
  - Stimulus: start pulsed again at E0+5; abort asserted at E0+10 in a separate run.
  - Response: the extra start has no effect; abort drops busy the next cycle with no done; tt_captured holds bits 0..2; {a_o,b_o,c_o}=000.
- Test 5:
  - Stimulus: rst_n low at E0+13, asynchronously mid-cycle.
  - Response: all outputs 0 immediately; a new start afterwards yields a clean pass with tt_captured=8'hE8.
- Test 6:
  - Stimulus: FUNCAO_TT_SYNC_EN defined; majority model.
  - Response: done at E0+41; tt_captured=8'hE8; pass=1.
